// File: rtl/pe_pkg.sv
// pe_pkg: shared types for the PE memory-port arbiter
package pe_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;
  typedef enum logic {REQ_CPU, REQ_DMA} req_id_t;
endpackage

// File: rtl/pe_mem_arbiter_sat_counter.sv
// pe_mem_arbiter_sat_counter: up-counter that sticks at all-ones
module pe_mem_arbiter_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/pe_mem_arbiter.sv
// pe_mem_arbiter: round-robin CPU/DDMA arbiter for the PE memory port with a
// bounded hold window and one-cycle tagged read return
module pe_mem_arbiter
  import pe_pkg::*;
#(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter int MAX_HOLD         = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        cpu_req,
  input  logic                        cpu_we,
  input  logic [ADDR_WIDTH-1:0]       cpu_addr,
  input  logic [MEMORY_BUS_WIDTH-1:0] cpu_wdata,
  output logic                        cpu_gnt,
  output logic [MEMORY_BUS_WIDTH-1:0] cpu_rdata,
  output logic                        cpu_rvalid,
  input  logic                        dma_req,
  input  logic                        dma_we,
  input  logic [ADDR_WIDTH-1:0]       dma_addr,
  input  logic [MEMORY_BUS_WIDTH-1:0] dma_wdata,
  output logic                        dma_gnt,
  output logic [MEMORY_BUS_WIDTH-1:0] dma_rdata,
  output logic                        dma_rvalid,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [MEMORY_BUS_WIDTH-1:0] mem_wdata,
  input  logic [MEMORY_BUS_WIDTH-1:0] mem_rdata,
  output logic [15:0]                 conflict_count
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  owner_t owner, grant_owner;
  req_id_t last_served, pend_tag, grant_id;
  logic [HW-1:0] hold_cnt;
  logic hold_live, pend_valid;
  assign hold_live = hold_cnt < HW'(MAX_HOLD);
  // CPU wins a tie if it holds a live window, or the DMA has no live window and was served last
  assign cpu_gnt = cpu_req & (!dma_req | (owner == OWN_CPU & hold_live) |
                   (!(owner == OWN_DMA & hold_live) & last_served == REQ_DMA));
  assign dma_gnt = dma_req & !cpu_gnt;
  assign mem_en = cpu_gnt | dma_gnt;
  assign grant_owner = cpu_gnt ? OWN_CPU : OWN_DMA;
  assign grant_id = cpu_gnt ? REQ_CPU : REQ_DMA;
  assign mem_we = cpu_gnt ? cpu_we : dma_gnt & dma_we;
  assign mem_addr = cpu_gnt ? cpu_addr : dma_gnt ? dma_addr : '0;
  assign mem_wdata = cpu_gnt ? cpu_wdata : dma_gnt ? dma_wdata : '0;
  assign cpu_rdata = mem_rdata;
  assign dma_rdata = mem_rdata;
  assign cpu_rvalid = pend_valid & pend_tag == REQ_CPU;
  assign dma_rvalid = pend_valid & pend_tag == REQ_DMA;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      owner <= OWN_NONE;
      last_served <= REQ_DMA;
      hold_cnt <= '0;
    end else if (mem_en) begin
      hold_cnt <= owner != grant_owner ? HW'(1) : hold_live ? hold_cnt + 1'b1 : hold_cnt;
      owner <= grant_owner;
      last_served <= grant_id;
    end else begin
      owner <= OWN_NONE;
      hold_cnt <= '0;
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      pend_valid <= 1'b0;
      pend_tag <= REQ_CPU;
    end else begin
      pend_valid <= mem_en & !mem_we;
      pend_tag <= grant_id;
    end
  pe_mem_arbiter_sat_counter #(.W(16)) u_conflict (
    .clk(clock),
    .rst(reset),
    .inc(cpu_req & dma_req),
    .count(conflict_count)
  );
endmodule

// File: tb/tb_pe_mem_arbiter.sv
// tb_pe_mem_arbiter: vector table, corner sequences and random traffic vs a behavioural model
module tb_pe_mem_arbiter;
  localparam int DW = 32, AW = 32, MH = 4;
  logic clock = 0, reset = 1;
  logic cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [AW-1:0] cpu_addr = 0, dma_addr = 0, mem_addr;
  logic [DW-1:0] cpu_wdata = 0, dma_wdata = 0, mem_wdata, mem_rdata = 0, cpu_rdata, dma_rdata;
  logic cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_en, mem_we;
  logic [15:0] conflict_count;
  int n_checks = 0, n_fail = 0;
  int m_owner, m_streak, m_last, m_pend, m_cc, m_g;

  pe_mem_arbiter #(.MEMORY_BUS_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_HOLD(MH)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_count(conflict_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic cr, cw; logic [31:0] ca, cd;
    logic dr, dw; logic [31:0] da, dd;
    logic eg_c, eg_d, e_we; logic [31:0] e_addr; logic e_crv, e_drv;
  } vec_t;
  vec_t vt[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int predict();
    if (!cpu_req && !dma_req) return 0;
    if (cpu_req && !dma_req) return 1;
    if (dma_req && !cpu_req) return 2;
    if (m_owner != 0 && m_streak < MH) return m_owner;
    return 3 - m_last;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_streak = 0; m_last = 2; m_pend = 0; m_cc = 0;
  endtask

  task automatic half();
    @(negedge clock);
    m_g = predict();
    check("cpu_gnt", 64'(cpu_gnt), 64'(m_g == 1));
    check("dma_gnt", 64'(dma_gnt), 64'(m_g == 2));
    check("mem_en", 64'(mem_en), 64'(m_g != 0));
    check("mem_we", 64'(mem_we), 64'(m_g == 1 ? cpu_we : m_g == 2 ? dma_we : 1'b0));
    check("mem_addr", 64'(mem_addr), 64'(m_g == 1 ? cpu_addr : m_g == 2 ? dma_addr : 0));
    check("mem_wdata", 64'(mem_wdata), 64'(m_g == 1 ? cpu_wdata : m_g == 2 ? dma_wdata : 0));
    check("cpu_rvalid", 64'(cpu_rvalid), 64'(m_pend == 1));
    check("dma_rvalid", 64'(dma_rvalid), 64'(m_pend == 2));
    if (m_pend == 1) check("cpu_rdata", 64'(cpu_rdata), 64'(mem_rdata));
    if (m_pend == 2) check("dma_rdata", 64'(dma_rdata), 64'(mem_rdata));
    check("conflict_count", 64'(conflict_count), 64'(m_cc));
  endtask

  task automatic adv();
    @(posedge clock);
    if (m_g != 0) begin
      m_streak = (m_g == m_owner) ? m_streak + 1 : 1;
      m_owner = m_g;
      m_last = m_g;
      m_pend = ((m_g == 1) ? cpu_we : dma_we) ? 0 : m_g;
    end else begin
      m_owner = 0; m_streak = 0; m_pend = 0;
    end
    if (cpu_req && dma_req) m_cc = (m_cc < 65535) ? m_cc + 1 : 65535;
    #1;
  endtask

  task automatic do_reset();
    reset = 1; cpu_req = 0; dma_req = 0; cpu_we = 0; dma_we = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 0;
  endtask

  initial begin
    int beats;
    vt[0] = '{1, 0, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0, 32'h100, 0, 0};
    vt[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vt[2] = '{1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0, 0, 32'h10, 0, 0};
    vt[3] = '{0, 0, 0, 0, 1, 0, 32'h20, 0, 0, 1, 0, 32'h20, 1, 0};
    vt[4] = '{1, 0, 32'h30, 0, 0, 0, 0, 0, 1, 0, 0, 32'h30, 0, 1};
    vt[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vt[6] = '{1, 1, 32'h40, 32'h55, 0, 0, 0, 0, 1, 0, 1, 32'h40, 0, 0};
    vt[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[8] = '{1, 0, 32'h1, 0, 1, 0, 32'h2, 0, 0, 1, 0, 32'h2, 0, 0};
    vt[9] = '{1, 0, 32'h1, 0, 1, 0, 32'h2, 0, 0, 1, 0, 32'h2, 0, 1};
    do_reset();
    check("reset_mem_en", 64'(mem_en), 0);
    check("reset_rvalid", 64'({cpu_rvalid, dma_rvalid}), 0);
    check("reset_conflict", 64'(conflict_count), 0);
    for (int i = 0; i < 10; i++) begin
      cpu_req = vt[i].cr; cpu_we = vt[i].cw; cpu_addr = vt[i].ca; cpu_wdata = vt[i].cd;
      dma_req = vt[i].dr; dma_we = vt[i].dw; dma_addr = vt[i].da; dma_wdata = vt[i].dd;
      mem_rdata = 32'hA000_0000 + 32'(i);
      half();
      check($sformatf("vec%0d_cgnt", i), 64'(cpu_gnt), 64'(vt[i].eg_c));
      check($sformatf("vec%0d_dgnt", i), 64'(dma_gnt), 64'(vt[i].eg_d));
      check($sformatf("vec%0d_we", i), 64'(mem_we), 64'(vt[i].e_we));
      check($sformatf("vec%0d_addr", i), 64'(mem_addr), 64'(vt[i].e_addr));
      check($sformatf("vec%0d_crv", i), 64'(cpu_rvalid), 64'(vt[i].e_crv));
      check($sformatf("vec%0d_drv", i), 64'(dma_rvalid), 64'(vt[i].e_drv));
      adv();
    end
    // both requesting from reset: CPU x4, DMA x4, CPU
    do_reset();
    cpu_req = 1; dma_req = 1; cpu_we = 0; dma_we = 0; cpu_addr = 32'h11; dma_addr = 32'h22;
    for (int i = 0; i < 9; i++) begin
      half();
      check($sformatf("tie%0d_cgnt", i), 64'(cpu_gnt), 64'(i < 4 || i == 8));
      if (i == 8) check("tie_conflict8", 64'(conflict_count), 8);
      adv();
    end
    // DMA write stream, CPU cuts in once after the window saturates
    do_reset();
    beats = 0; dma_we = 1; cpu_we = 0; cpu_addr = 32'h300;
    for (int i = 0; i < 22; i++) begin
      cpu_req = (i == 10); dma_req = beats < 20; dma_addr = 32'(beats); dma_wdata = 32'(beats * 3);
      half();
      if (i == 9) check("stream_dma_holds", 64'(dma_gnt), 1);
      if (i == 10) check("stream_cpu_cut_in", 64'({cpu_gnt, dma_gnt}), 64'b10);
      if (i == 11) check("stream_dma_regrant", 64'({cpu_gnt, dma_gnt}), 64'b01);
      if (m_g == 2) beats++;
      adv();
    end
    check("stream_beats", 64'(beats), 20);
    // reset lands between a granted read and its return
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
    @(negedge clock);
    check("midrd_gnt", 64'(cpu_gnt), 1);
    #1 reset = 1; cpu_req = 0;
    #1;
    check("midrd_outs", 64'({cpu_gnt, dma_gnt, mem_en, mem_we, cpu_rvalid, dma_rvalid}), 0);
    check("midrd_addr", 64'({mem_addr, mem_wdata}), 0);
    check("midrd_cc", 64'(conflict_count), 0);
    model_reset();
    @(posedge clock);
    #1 reset = 0;
    half();
    check("midrd_no_rvalid", 64'(cpu_rvalid), 0);
    adv();
    // random traffic, requests held until granted
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (!cpu_req || m_g == 1) begin
        cpu_req = $urandom_range(0, 2) != 0; cpu_we = $urandom_range(0, 1) == 1;
        cpu_addr = $urandom; cpu_wdata = $urandom;
      end
      if (!dma_req || m_g == 2) begin
        dma_req = $urandom_range(0, 2) != 0; dma_we = $urandom_range(0, 1) == 1;
        dma_addr = $urandom; dma_wdata = $urandom;
      end
      mem_rdata = $urandom;
      m_g = 0;
      half();
      adv();
    end
    // conflict counter saturation
    do_reset();
    cpu_req = 1; dma_req = 1;
    repeat (70000) begin
      half();
      adv();
    end
    half();
    check("conflict_sat", 64'(conflict_count), 64'h FFFF);
    adv();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
